// File: rtl/jump_ctrl.sv
// Jump game controller: charge while the key is held, jump on release, score the landing.
// Optional `KEY_DEBOUNCE_EN adds a 65536-cycle stability filter after the key synchronizer.
module jump_ctrl #(
  parameter int TICK_DIV   = 524288,
  parameter int CHARGE_MAX = 63,
  parameter int JUMP_GAIN  = 4,
  parameter int STEP       = 8,
  parameter int TOL        = 6
) (
  input  logic       clk_machine,
  input  logic       rst_machine,
  input  logic       key_jump,
  input  logic       start,
  input  logic [7:0] target_dist,
  output logic [2:0] state,
  output logic [5:0] charge,
  output logic [7:0] man_pos,
  output logic [7:0] score,
  output logic       land_ok,
  output logic       game_over
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READY = 3'd1;
  localparam logic [2:0] LAND  = 3'd2;
  localparam logic [2:0] ACCU  = 3'd3;
  localparam logic [2:0] JUMP  = 3'd4;
  localparam logic [2:0] OVER  = 3'd5;

  localparam int         CW   = $clog2(TICK_DIV);
  localparam logic [5:0] CMAX = 6'(CHARGE_MAX);

  logic [2:0]    state_reg, state_next;
  logic [1:0]    sync_reg;
  logic          key;
  logic          key_prev_reg;
  logic [CW-1:0] div_reg;
  logic          tick;
  logic [5:0]    charge_reg;
  logic [7:0]    man_pos_reg, dist_reg, target_reg, score_reg;
  logic [15:0]   prod;
  logic [7:0]    dist_calc;
  logic [8:0]    pos_sum;
  logic [7:0]    pos_step;
  logic [7:0]    diff;
  logic          land_hit;
  logic          key_rise;

  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) sync_reg <= 2'b00;
    else             sync_reg <= {sync_reg[0], key_jump};
  end

`ifdef KEY_DEBOUNCE_EN
  logic        key_db_reg;
  logic [15:0] db_cnt_reg;

  // The filtered level only follows the synchronizer after it has disagreed for 65536 cycles.
  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) begin
      key_db_reg <= 1'b0;
      db_cnt_reg <= 16'd0;
    end else if (sync_reg[1] == key_db_reg) begin
      db_cnt_reg <= 16'd0;
    end else if (db_cnt_reg == 16'hFFFF) begin
      key_db_reg <= sync_reg[1];
      db_cnt_reg <= 16'd0;
    end else begin
      db_cnt_reg <= db_cnt_reg + 16'd1;
    end
  end

  assign key = key_db_reg;
`else
  assign key = sync_reg[1];
`endif

  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) begin
      div_reg      <= '0;
      key_prev_reg <= 1'b0;
    end else begin
      div_reg      <= tick ? '0 : div_reg + 1'b1;
      key_prev_reg <= key;
    end
  end

  assign tick     = (div_reg == CW'(TICK_DIV - 1));
  assign key_rise = key && !key_prev_reg;

  assign prod      = 16'(charge_reg) * 16'(JUMP_GAIN);
  assign dist_calc = (prod > 16'd255) ? 8'hFF : prod[7:0];
  // Nine-bit sum so a step past 255 clamps to dist instead of wrapping.
  assign pos_sum   = {1'b0, man_pos_reg} + 9'(STEP);
  assign pos_step  = (pos_sum > {1'b0, dist_reg}) ? dist_reg : pos_sum[7:0];
  assign diff      = (dist_reg >= target_reg) ? (dist_reg - target_reg) : (target_reg - dist_reg);
  assign land_hit  = ({1'b0, diff} <= 9'(TOL));

  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) state_reg <= IDLE;
    else             state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = READY;
      READY:   if (key_rise) state_next = ACCU;
      ACCU:    if (!key) state_next = JUMP;
      JUMP:    if (man_pos_reg == dist_reg) state_next = LAND;
      LAND:    state_next = land_hit ? READY : OVER;
      OVER:    if (start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) begin
      charge_reg  <= 6'd0;
      man_pos_reg <= 8'd0;
      dist_reg    <= 8'd0;
      target_reg  <= 8'd0;
      score_reg   <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          score_reg  <= 8'd0;
          charge_reg <= 6'd0;
        end
        READY: if (key_rise) charge_reg <= 6'd0;
        // Release wins over a coincident tick, so the last tick never adds charge.
        ACCU: if (!key) begin
          dist_reg    <= dist_calc;
          target_reg  <= target_dist;
          man_pos_reg <= 8'd0;
        end else if (tick && charge_reg < CMAX) begin
          charge_reg <= charge_reg + 6'd1;
        end
        JUMP: if (man_pos_reg != dist_reg && tick) man_pos_reg <= pos_step;
        LAND: if (land_hit) begin
          charge_reg <= 6'd0;
          if (score_reg != 8'hFF) score_reg <= score_reg + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state     = state_reg;
    charge    = charge_reg;
    man_pos   = man_pos_reg;
    score     = score_reg;
    game_over = (state_reg == OVER);
    land_ok   = (state_reg == LAND) && land_hit;
  end

endmodule

// File: tb/tb_jump_ctrl.sv
// Scoreboard bench for jump_ctrl with TICK_DIV=4: expected landings and jump steps are queued
// by the stimulus and consumed by a monitor whenever the DUT is in LAND or advances in JUMP.
module tb_jump_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key;
  logic       start;
  logic [7:0] target_dist;
  logic [2:0] state;
  logic [5:0] charge;
  logic [7:0] man_pos;
  logic [7:0] score;
  logic       land_ok;
  logic       game_over;

  jump_ctrl #(.TICK_DIV(4)) dut (
    .clk_machine(clk),
    .rst_machine(rst),
    .key_jump(key),
    .start(start),
    .target_dist(target_dist),
    .state(state),
    .charge(charge),
    .man_pos(man_pos),
    .score(score),
    .land_ok(land_ok),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    int d;
    int ok;
    int sc;
  } land_t;

  land_t      land_q[$];
  logic [7:0] step_q[$];
  int         checks = 0;
  int         failures = 0;
  int         exp_score = 0;
  bit         step_en = 1'b0;
  logic [7:0] prev_pos = 8'd0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: one line per observed landing, comparisons against the queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (state == 3'd2) begin
        if (land_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_land actual=charge %0d pos %0d required=no landing", charge, man_pos);
        end else begin
          land_t e;
          e = land_q.pop_front();
          $display("land: charge=%0d dist=%0d land_ok=%0d score=%0d", charge, man_pos, land_ok, score);
          check("land_charge", charge, e.c);
          check("land_dist", man_pos, e.d);
          check("land_ok", land_ok, e.ok);
          check("land_score", score, e.sc);
        end
      end else if (land_ok) begin
        checks++;
        failures++;
        $display("FAIL stray_land_ok actual=1 required=0 state=%0d", state);
      end
      if (state == 3'd4 && step_en && man_pos != prev_pos && man_pos != 8'd0) begin
        if (step_q.size() == 0) check("unexpected_step", man_pos, -1);
        else check("jump_step", man_pos, step_q.pop_front());
      end
      prev_pos = man_pos;
    end
  end

  task automatic expect_land(input int c, input int d, input int ok);
    land_t r;
    int p;
    r.c = c; r.d = d; r.ok = ok; r.sc = exp_score;
    land_q.push_back(r);
    p = 0;
    while (p < d) begin
      p = p + 8;
      if (p > d) p = d;
      step_q.push_back(8'(p));
    end
    if (ok != 0 && exp_score < 255) exp_score++;
  endtask

  // Key high for exactly h cycles; ACCU then sees h-1 key-high edges (h=4n+1 gives n ticks).
  task automatic press(input int h, input logic [7:0] tgt);
    target_dist = tgt;
    @(negedge clk) key = 1'b1;
    repeat (h) @(negedge clk);
    key = 1'b0;
  endtask

  task automatic wait_land(input string name);
    int n;
    n = 0;
    while (state != 3'd2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, (n < 2000) ? 1 : 0, 1);
    @(negedge clk);
  endtask

  task automatic pulse_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  initial begin
    int n;
    int jc;
    rst = 1'b1; key = 1'b0; start = 1'b0; target_dist = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_state", state, 0);
    check("reset_charge", charge, 0);
    check("reset_score", score, 0);
    check("reset_game_over", game_over, 0);

    // Reset in mid-jump at man_pos=16: no landing is queued, so any LAND is flagged.
    pulse_start;
    check("start_to_ready", state, 1);
    press(41, 8'd40);
    n = 0;
    while (!(state == 3'd4 && man_pos == 8'd16) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reach_pos16", (n < 500) ? 1 : 0, 1);
    #1 rst = 1'b1;
    #1;
    check("midjump_rst_state", state, 0);
    check("midjump_rst_pos", man_pos, 0);
    check("midjump_rst_charge", charge, 0);
    check("midjump_rst_score", score, 0);
    check("midjump_rst_land_ok", land_ok, 0);
    check("midjump_rst_game_over", game_over, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", state, 0);
    step_en = 1'b1;

    // Ten ticks of charge, target 40: steps 8..40 and a successful landing.
    pulse_start;
    exp_score = 0;
    expect_land(10, 40, 1);
    press(41, 8'd40);
    wait_land("land10_seen");
    check("land10_state", state, 1);
    check("land10_score", score, exp_score);
    check("ready_charge_clear", charge, 0);

    // charge 11 -> dist 44, |diff|=4: success.
    expect_land(11, 44, 1);
    press(45, 8'd40);
    wait_land("land11_seen");
    check("land11_state", state, 1);

    // Key re-pressed during the jump and held into READY must not start a new charge.
    expect_land(1, 4, 1);
    target_dist = 8'd0;
    @(negedge clk) key = 1'b1;
    repeat (5) @(negedge clk);
    key = 1'b0;
    @(negedge clk) key = 1'b1;
    wait_land("held_land_seen");
    repeat (20) @(negedge clk);
    check("held_key_ready", state, 1);
    check("held_key_charge", charge, 0);
    key = 1'b0;
    repeat (6) @(negedge clk);
    check("released_ready", state, 1);

    // Press and release inside one tick: charge 0, dist 0, a single JUMP cycle.
    expect_land(0, 0, 1);
    press(1, 8'd0);
    n = 0; jc = 0;
    while (state != 3'd2 && n < 100) begin
      if (state == 3'd4) jc++;
      @(negedge clk);
      n++;
    end
    check("zero_jump_cycles", jc, 1);
    @(negedge clk);
    check("zero_land_state", state, 1);

    // charge 12 -> dist 48, |diff|=8: game over, score held through OVER and IDLE.
    expect_land(12, 48, 0);
    press(49, 8'd40);
    wait_land("land12_seen");
    check("miss_state", state, 5);
    check("miss_game_over", game_over, 1);
    check("miss_score_hold", score, exp_score);
    pulse_start;
    check("over_to_idle", state, 0);
    check("idle_score_hold", score, exp_score);
    pulse_start;
    exp_score = 0;
    check("restart_ready", state, 1);
    check("restart_score", score, 0);
    pulse_start;
    check("start_ignored_ready", state, 1);

    // 100 ticks saturate charge at 63 -> dist 252, target 100: miss.
    expect_land(63, 252, 0);
    press(401, 8'd100);
    wait_land("sat_land_seen");
    check("sat_state", state, 5);
    check("sat_game_over", game_over, 1);
    pulse_start;
    check("sat_to_idle", state, 0);
    pulse_start;
    exp_score = 0;

    // 256 zero-distance landings: score climbs to 255 and then holds.
    for (int i = 0; i < 256; i++) begin
      expect_land(0, 0, 1);
      press(1, 8'd0);
      wait_land("loop_land_seen");
      repeat (3) @(negedge clk);
    end
    check("score_saturated", score, 255);
    check("loop_state", state, 1);

    check("land_q_drained", land_q.size(), 0);
    check("step_q_drained", step_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
